// File: rtl/mul_wb_buffer.sv
// Result buffer behind the 3-stage MUL unit: tracks rd tags of in-flight multiplies,
// queues retired results and hands them to the shared writeback port with credit control.
module mul_wb_buffer #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4,
  parameter int LAT   = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             kill_i,
  input  logic             issue_i,
  input  logic [TAG_W-1:0] issue_rd_i,
  input  logic             mul_valid_i,
  input  logic [XLEN-1:0]  mul_result_i,
  output logic             issue_ok_o,
  output logic             wb_valid_o,
  output logic [TAG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  input  logic             wb_ready_i,
  output logic             err_o
);

  // Writeback handshake: an entry transfers on any cycle where wb_valid_o and
  // wb_ready_i are both high; wb_rd_o/wb_data_o hold steady while valid and not ready.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int INF_W = $clog2(LAT) + 1;
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic [LAT-1:0]   v_q, v_d;
  logic [TAG_W-1:0] rd_q [LAT];
  logic [TAG_W-1:0] rd_d [LAT];

  logic [TAG_W-1:0] mem_rd_q   [DEPTH];
  logic [XLEN-1:0]  mem_data_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             cap, full, push, pop;
  logic [INF_W-1:0] inflight;
  logic [SUM_W-1:0] credit_sum;

  always_comb begin
    v_d  = v_q;
    rd_d = rd_q;
    if (kill_i) begin
      v_d = '0;
    end else if (!stall_i) begin
      for (int k = LAT - 1; k > 0; k--) begin
        v_d[k]  = v_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[0]  = issue_i;
      rd_d[0] = issue_rd_i;
    end
  end

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      inflight = inflight + INF_W'(v_q[k]);
    end
  end

  assign cap  = mul_valid_i & ~stall_i & ~kill_i;
  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = wb_valid_o & wb_ready_i;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push = cap & (~full | pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    if (cap && !v_q[LAT-1])      err_d = 1'b1;
    if (cap && full && !pop)     err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_q     <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < LAT; k++) rd_q[k] <= '0;
    end else begin
      v_q     <= v_d;
      rd_q    <= rd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage needs no reset: outputs are masked by the count when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rd_q[wptr_q]   <= rd_q[LAT-1];
      mem_data_q[wptr_q] <= mul_result_i;
    end
  end

  assign credit_sum = SUM_W'(count_q) + SUM_W'(inflight);
  assign issue_ok_o = (credit_sum < SUM_W'(DEPTH));
  assign wb_valid_o = (count_q != '0);
  assign wb_rd_o    = wb_valid_o ? mem_rd_q[rptr_q]   : '0;
  assign wb_data_o  = wb_valid_o ? mem_data_q[rptr_q] : '0;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mul_wb_buffer.sv
// Directed bench for mul_wb_buffer: latency, stalls, backpressure, credit, kill,
// full-FIFO pass-through and reset, each checked against hand-computed values.
module tb_mul_wb_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, kill_i, issue_i;
  logic [4:0]  issue_rd_i;
  logic        mul_valid_i;
  logic [31:0] mul_result_i;
  logic        issue_ok_o, wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_ready_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mul_wb_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .kill_i(kill_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .mul_valid_i(mul_valid_i),
    .mul_result_i(mul_result_i), .issue_ok_o(issue_ok_o), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i), .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; kill_i = 1'b0; issue_i = 1'b0; issue_rd_i = '0;
    mul_valid_i = 1'b0; mul_result_i = '0; wb_ready_i = 1'b0;
    tick(); tick();
    chk("rst_wb_valid", 32'(wb_valid_o), 0);
    chk("rst_wb_rd", 32'(wb_rd_o), 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_issue_ok", 32'(issue_ok_o), 1);
    rst_i = 1'b1;
    tick();

    // 1: single MUL, visible at issue+4 for one cycle
    issue_i = 1'b1; issue_rd_i = 5'd5; wb_ready_i = 1'b1;
    tick();
    issue_i = 1'b0;
    chk("t1_ok_inflight", 32'(issue_ok_o), 1);
    tick();
    tick();
    mul_valid_i = 1'b1; mul_result_i = 32'h0000_002A;
    chk("t1_valid_early", 32'(wb_valid_o), 0);
    tick();
    mul_valid_i = 1'b0;
    chk("t1_valid", 32'(wb_valid_o), 1);
    chk("t1_rd", 32'(wb_rd_o), 5);
    chk("t1_data", wb_data_o, 32'h2A);
    tick();
    chk("t1_valid_gone", 32'(wb_valid_o), 0);
    chk("t1_err", 32'(err_o), 0);

    // 2: two stall cycles with result held valid -> one push, visible at issue+6
    wb_ready_i = 1'b0;
    issue_i = 1'b1; issue_rd_i = 5'd7;
    tick();
    issue_i = 1'b0;
    tick();
    tick();
    mul_valid_i = 1'b1; mul_result_i = 32'h1234_5678; stall_i = 1'b1;
    tick();
    chk("t2_valid_stall", 32'(wb_valid_o), 0);
    tick();
    stall_i = 1'b0;
    chk("t2_valid_stall2", 32'(wb_valid_o), 0);
    tick();
    mul_valid_i = 1'b0;
    chk("t2_valid", 32'(wb_valid_o), 1);
    chk("t2_rd", 32'(wb_rd_o), 7);
    chk("t2_data", wb_data_o, 32'h1234_5678);
    chk("t2_err", 32'(err_o), 0);
    tick();
    chk("t2_hold_valid", 32'(wb_valid_o), 1);
    chk("t2_hold_data", wb_data_o, 32'h1234_5678);
    wb_ready_i = 1'b1;
    tick();
    chk("t2_empty", 32'(wb_valid_o), 0);
    chk("t2_ok", 32'(issue_ok_o), 1);

    // 3: backpressure, four results, credits run out, order kept
    wb_ready_i = 1'b0;
    issue_i = 1'b1; issue_rd_i = 5'd1;
    chk("t3_ok_c0", 32'(issue_ok_o), 1);
    tick();
    issue_rd_i = 5'd2;
    chk("t3_ok_c1", 32'(issue_ok_o), 1);
    tick();
    issue_rd_i = 5'd3;
    chk("t3_ok_c2", 32'(issue_ok_o), 1);
    tick();
    issue_rd_i = 5'd4; mul_valid_i = 1'b1; mul_result_i = 32'h1111_1111;
    chk("t3_ok_c3", 32'(issue_ok_o), 1);
    tick();
    issue_i = 1'b0; mul_result_i = 32'h2222_2222;
    chk("t3_ok_c4", 32'(issue_ok_o), 0);
    tick();
    mul_result_i = 32'h3333_3333;
    chk("t3_ok_c5", 32'(issue_ok_o), 0);
    tick();
    mul_result_i = 32'h4444_4444;
    chk("t3_ok_c6", 32'(issue_ok_o), 0);
    tick();
    mul_valid_i = 1'b0;
    chk("t3_ok_full", 32'(issue_ok_o), 0);
    chk("t3_rd1", 32'(wb_rd_o), 1);
    chk("t3_data1", wb_data_o, 32'h1111_1111);
    chk("t3_err", 32'(err_o), 0);
    wb_ready_i = 1'b1;
    tick();
    chk("t3_rd2", 32'(wb_rd_o), 2);
    chk("t3_data2", wb_data_o, 32'h2222_2222);
    tick();
    chk("t3_rd3", 32'(wb_rd_o), 3);
    chk("t3_data3", wb_data_o, 32'h3333_3333);
    tick();
    chk("t3_rd4", 32'(wb_rd_o), 4);
    chk("t3_data4", wb_data_o, 32'h4444_4444);
    tick();
    chk("t3_empty", 32'(wb_valid_o), 0);
    chk("t3_ok_after", 32'(issue_ok_o), 1);

    // 5: full FIFO, pop and capture in the same cycle
    wb_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      issue_i      = (c < 5);
      issue_rd_i   = 5'(10 + c);
      mul_valid_i  = (c >= 3);
      mul_result_i = 32'(160 + c - 3);
      wb_ready_i   = (c == 7);
      if (c == 7) begin
        chk("t5_full_valid", 32'(wb_valid_o), 1);
        chk("t5_full_rd", 32'(wb_rd_o), 10);
        chk("t5_full_data", wb_data_o, 32'hA0);
      end
      tick();
    end
    issue_i = 1'b0; mul_valid_i = 1'b0;
    chk("t5_rd11", 32'(wb_rd_o), 11);
    chk("t5_data11", wb_data_o, 32'hA1);
    chk("t5_count4", 32'(issue_ok_o), 0);
    chk("t5_err", 32'(err_o), 0);
    tick();
    chk("t5_rd12", 32'(wb_rd_o), 12);
    tick();
    chk("t5_rd13", 32'(wb_rd_o), 13);
    tick();
    chk("t5_rd14", 32'(wb_rd_o), 14);
    chk("t5_data14", wb_data_o, 32'hA4);
    tick();
    chk("t5_empty", 32'(wb_valid_o), 0);

    // 4: kill with rd=9 in flight, then a stray result
    wb_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      issue_i      = (c < 3);
      issue_rd_i   = 5'(1 + c);
      mul_valid_i  = (c >= 3);
      mul_result_i = 32'(176 + c - 3);
      tick();
    end
    mul_valid_i = 1'b0;
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_i = 1'b0;
    chk("t4_ok_before_kill", 32'(issue_ok_o), 0);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("t4_ok_after_kill", 32'(issue_ok_o), 1);
    tick();
    mul_valid_i = 1'b1; mul_result_i = 32'hDEAD_BEEF;
    chk("t4_err_before", 32'(err_o), 0);
    tick();
    mul_valid_i = 1'b0;
    chk("t4_err_set", 32'(err_o), 1);
    chk("t4_ok_full", 32'(issue_ok_o), 0);
    chk("t4_rd1", 32'(wb_rd_o), 1);
    chk("t4_data1", wb_data_o, 32'hB0);
    wb_ready_i = 1'b1;
    tick();
    chk("t4_data2", wb_data_o, 32'hB1);
    tick();
    chk("t4_data3", wb_data_o, 32'hB2);
    tick();
    chk("t4_data_stray", wb_data_o, 32'hDEAD_BEEF);
    tick();
    chk("t4_empty", 32'(wb_valid_o), 0);
    chk("t4_err_sticky", 32'(err_o), 1);

    // 6: reset with two queued entries
    wb_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      issue_i      = (c < 2);
      issue_rd_i   = 5'(20 + c);
      mul_valid_i  = (c >= 3);
      mul_result_i = 32'(192 + c - 3);
      tick();
    end
    mul_valid_i = 1'b0;
    chk("t6_queued_valid", 32'(wb_valid_o), 1);
    chk("t6_queued_rd", 32'(wb_rd_o), 20);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("t6_wb_valid", 32'(wb_valid_o), 0);
    chk("t6_issue_ok", 32'(issue_ok_o), 1);
    chk("t6_err", 32'(err_o), 0);
    chk("t6_wb_data", wb_data_o, 0);
    chk("t6_wb_rd", 32'(wb_rd_o), 0);
    tick();
    chk("t6_still_empty", 32'(wb_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
